// File: rtl/rf_txn_arbiter.sv
// rf_txn_arbiter: two-client round-robin arbiter in front of a single-port
// register file. Each granted transaction reads the selected register and,
// for write/add/sub, writes the new value back one cycle later.
// Optional build macro RF_ARB_OVF_CHECK_EN: add carry-out or sub borrow
// aborts the write and reports err with the ack. When the macro is not
// defined, add/sub wrap modulo 2^DW and err is tied low.
module rf_txn_arbiter #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [1:0]    op0,
    input  logic [1:0]    op1,
    input  logic [AW-1:0] sel0,
    input  logic [AW-1:0] sel1,
    input  logic [DW-1:0] wd0,
    input  logic [DW-1:0] wd1,
    output logic [1:0]    ack,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          rf_we,
    output logic [AW-1:0] rf_sel,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_SUB   = 2'b11;

    logic [1:0]    r_state;
    logic          r_gnt;
    logic          r_last;
    logic [1:0]    r_op;
    logic [AW-1:0] r_sel;
    logic [DW-1:0] r_wd;
    logic [1:0]    r_ack;
    logic [DW-1:0] r_rdata;
    logic          r_we;
    logic [DW-1:0] r_wdata;

    logic          w_pick;
    logic [1:0]    w_pickOp;
    logic [AW-1:0] w_pickSel;
    logic [DW-1:0] w_pickWd;
    logic [DW-1:0] w_sum;
    logic [DW-1:0] w_diff;
    logic [DW-1:0] w_result;
    logic          w_ovf;
    logic [1:0]    w_ackOneHot;

`ifdef RF_ARB_OVF_CHECK_EN
    logic          r_err;
    logic          w_carry;

    assign {w_carry, w_sum} = {1'b0, rf_rdata} + {1'b0, r_wd};
    assign w_ovf = ((r_op == OP_ADD) && w_carry) ||
                   ((r_op == OP_SUB) && (r_wd > rf_rdata));
    assign err   = r_err;
`else
    assign w_sum = rf_rdata + r_wd;
    assign w_ovf = 1'b0;
    assign err   = 1'b0;
`endif

    assign w_diff      = rf_rdata - r_wd;
    assign w_ackOneHot = r_gnt ? 2'b10 : 2'b01;

    assign ack      = r_ack;
    assign rdata    = r_rdata;
    assign rf_we    = r_we;
    assign rf_sel   = r_sel;
    assign rf_wdata = r_wdata;

    // Round-robin pick: a lone requester wins, a tie goes to the client not served last
    always_comb begin
        w_pick = 1'b0;
        if (req == 2'b11) begin
            w_pick = ~r_last;
        end else begin
            w_pick = req[1];
        end
    end

    // Mux the winning client's transaction fields so they can be latched at grant
    always_comb begin
        w_pickOp  = op0;
        w_pickSel = sel0;
        w_pickWd  = wd0;
        if (w_pick) begin
            w_pickOp  = op1;
            w_pickSel = sel1;
            w_pickWd  = wd1;
        end
    end

    // Value that write/add/sub commits back to the register file
    always_comb begin
        w_result = rf_rdata;
        case (r_op)
            OP_WRITE: w_result = r_wd;
            OP_ADD:   w_result = w_sum;
            OP_SUB:   w_result = w_diff;
            default:  w_result = rf_rdata;
        endcase
    end

    // Transaction FSM: grant in IDLE, read in RD, optional write in WR, ack in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_op    <= OP_READ;
            r_sel   <= '0;
            r_wd    <= '0;
            r_ack   <= 2'b00;
            r_rdata <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
`ifdef RF_ARB_OVF_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= 2'b00;
                    if (|req) begin
                        r_gnt   <= w_pick;
                        r_last  <= w_pick;
                        r_op    <= w_pickOp;
                        r_sel   <= w_pickSel;
                        r_wd    <= w_pickWd;
                        r_state <= S_RD;
                    end
                end
                S_RD: begin
                    if (r_op == OP_READ) begin
                        r_rdata <= rf_rdata;
                        r_ack   <= w_ackOneHot;
                        r_state <= S_DONE;
                    end else if (w_ovf) begin
                        r_rdata <= rf_rdata;
                        r_ack   <= w_ackOneHot;
`ifdef RF_ARB_OVF_CHECK_EN
                        r_err   <= 1'b1;
`endif
                        r_state <= S_DONE;
                    end else begin
                        r_we    <= 1'b1;
                        r_wdata <= w_result;
                        r_state <= S_WR;
                    end
                end
                S_WR: begin
                    r_we    <= 1'b0;
                    r_rdata <= r_wdata;
                    r_ack   <= w_ackOneHot;
                    r_state <= S_DONE;
                end
                default: begin
                    r_ack   <= 2'b00;
`ifdef RF_ARB_OVF_CHECK_EN
                    r_err   <= 1'b0;
`endif
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rf_txn_arbiter.md
RF_TXN_ARBITER -- requirements
Module: rf_txn_arbiter

Interface
REQ-001 Parameter DW, default 32, register data width.
REQ-002 Parameter AW, default 4, register select width (16 entries).
REQ-003 The block SHALL use clock clk and reset rst, asynchronous, active-high.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req  input  2  per-client request; bit i = client i; held high until ack[i].
REQ-007 op0, op1  input  2 each  client opcode: 00 read, 01 write, 10 add, 11 sub.
REQ-008 sel0, sel1  input  AW each  client register index.
REQ-009 wd0, wd1  input  DW each  client write data / operand.
REQ-010 ack  output  2  one-cycle completion pulse per client.
REQ-011 rdata  output  DW  shared result, valid in the ack cycle.
REQ-012 err  output  1  arithmetic error flag, valid in the ack cycle.
REQ-013 rf_we  output  1  register file write enable.
REQ-014 rf_sel  output  AW  register file index.
REQ-015 rf_wdata  output  DW  register file write data.
REQ-016 rf_rdata  input  DW  register file combinational read data for rf_sel.

Function
REQ-017 FSM states SHALL be IDLE, RD, WR, DONE.
REQ-018 IDLE: if any req bit is set, grant one client, latch its op/sel/wd, and go to RD; otherwise stay.
REQ-019 Arbitration SHALL be round-robin: a lone requester wins; if both request, the client not served last wins.
REQ-020 RD: rf_sel = latched sel; capture rf_rdata; read goes to DONE; write/add/sub goes to WR.
REQ-021 WR: rf_we = 1 for exactly one cycle; rf_wdata = wd (write), old+wd (add) or old-wd (sub); then DONE.
REQ-022 DONE: ack[granted] = 1 for one cycle; rdata and err driven; next state IDLE.
REQ-023 Latency from IDLE grant to ack SHALL be 2 cycles for read and 3 cycles for write/add/sub.
REQ-024 rdata SHALL be: the current value for read, wd for write, the new value for add/sub, or the unchanged old value on err.
REQ-025 rf_we SHALL be 0 in every state except WR; rf_sel SHALL hold the latched sel in RD, WR and DONE.
REQ-026 Requests arriving outside IDLE SHALL wait; a req still high in the cycle after ack SHALL be treated as a new request.
REQ-027 Arithmetic SHALL be unsigned, DW bits wide.
REQ-028 Changes to a client's inputs after its grant SHALL have no effect on the transaction in flight.

Reset
REQ-029 On rst: state IDLE, ack = 0, rdata = 0, err = 0, rf_we = 0, rf_sel = 0, rf_wdata = 0, round-robin pointer favouring client 0.
REQ-030 rst asserted mid-transaction SHALL abort it: no write is issued and no ack is produced.

Configuration
REQ-031 Macro RF_ARB_OVF_CHECK_EN defined: an add with carry-out or a sub with wd > old SHALL skip WR (no write) and return err = 1 with ack, 2-cycle latency.
REQ-032 Macro RF_ARB_OVF_CHECK_EN undefined: add/sub SHALL wrap modulo 2^DW, always write, and err SHALL be tied 0.

Verification
REQ-033 After rst, client0 write sel=3 wd=0x64 -> rf_we pulses once with rf_sel=3 and rf_wdata=0x64; ack[0] arrives 3 cycles after grant with rdata=0x64.
REQ-034 Client0 read sel=3 after REQ-033 -> ack[0] arrives 2 cycles after grant with rdata=0x64 and rf_we never asserted.
REQ-035 req=2'b11 held continuously with reads -> grants alternate 0,1,0,1 with no client served twice in a row.
REQ-036 reg3=0x64, client1 sub wd=0xC8 -> with macro: err=1, rdata=0x64, no write; without macro: rdata=0xFFFFFF9C, reg3 written with that value.
REQ-037 rst asserted while the FSM is in RD of an add -> no rf_we pulse and no ack; state IDLE and all outputs 0 afterwards.
REQ-038 Client0 add wd=0x10 on reg5=0x20 while client1 raises req mid-transaction -> client0 gets ack with rdata=0x30 first; client1 is granted in the next IDLE.
